// File: rtl/axil_bram_ctrl.sv
// AXI4-Lite slave in front of a single-port-per-direction block RAM, with independent read and write paths.
// Define AXIL_BRAM_BOUNDS_CHECK_EN to answer out-of-range word indices with SLVERR; without it they wrap.
module axil_bram_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                    s_aclk,
  input  logic                    s_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = ADDR_WIDTH - OffW;
  localparam int unsigned RamAw = $clog2(DEPTH);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rd_state_e;

  // Keeps every ready low until the first clock edge after reset release.
  logic rdy_en_q;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_e          wr_state_q, wr_state_d;
  logic               aw_full_q, aw_full_d;
  logic               w_full_q, w_full_d;
  logic [IdxW-1:0]    aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               aw_hs, w_hs, ram_we, aw_oob;
  logic [RamAw-1:0]   aw_ram_idx;

  assign s_axi_awready = rdy_en_q && (wr_state_q == W_IDLE) && !aw_full_q;
  assign s_axi_wready  = rdy_en_q && (wr_state_q == W_IDLE) && !w_full_q;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign aw_ram_idx    = aw_idx_q[RamAw-1:0];
  assign s_axi_bvalid  = (wr_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;

`ifdef AXIL_BRAM_BOUNDS_CHECK_EN
  assign aw_oob = 32'(aw_idx_q) >= DEPTH;
`else
  assign aw_oob = 1'b0;
`endif

  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    ram_we     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[ADDR_WIDTH-1:OffW];
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        // Leave as soon as the second half arrives so the response lands two cycles later.
        if (aw_full_d && w_full_d) begin
          wr_state_d = W_EXEC;
        end
      end
      W_EXEC: begin
        ram_we     = !aw_oob;
        bresp_d    = aw_oob ? RespSlvErr : RespOkay;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wr_state_d = W_IDLE;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      wr_state_q <= W_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RespOkay;
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_e          rd_state_q, rd_state_d;
  logic [IdxW-1:0]    ar_idx_q, ar_idx_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic               ar_hs, rd_load, ar_oob;
  logic [RamAw-1:0]   ar_ram_idx;

  assign s_axi_arready = rdy_en_q && (rd_state_q == R_IDLE);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign ar_ram_idx    = ar_idx_q[RamAw-1:0];
  assign s_axi_rvalid  = (rd_state_q == R_RESP);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

`ifdef AXIL_BRAM_BOUNDS_CHECK_EN
  assign ar_oob = 32'(ar_idx_q) >= DEPTH;
`else
  assign ar_oob = 1'b0;
`endif

  always_comb begin
    rd_state_d = rd_state_q;
    ar_idx_d   = ar_idx_q;
    rresp_d    = rresp_q;
    rd_load    = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          ar_idx_d   = s_axi_araddr[ADDR_WIDTH-1:OffW];
          rd_state_d = R_READ;
        end
      end
      R_READ: begin
        rd_load    = 1'b1;
        rresp_d    = ar_oob ? RespSlvErr : RespOkay;
        rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      rd_state_q <= R_IDLE;
      ar_idx_q   <= '0;
      rresp_q    <= RespOkay;
    end else begin
      rd_state_q <= rd_state_d;
      ar_idx_q   <= ar_idx_d;
      rresp_q    <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset so contents survive s_aresetn. Both ports use the array
  // value from before the edge, which makes a same-word collision read-first.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge s_aclk) begin
    if (ram_we) begin
      for (int i = 0; i < StrbW; i++) begin
        if (wstrb_q[i]) begin
          mem_q[aw_ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= ar_oob ? '0 : mem_q[ar_ram_idx];
    end
  end

  // Byte-offset bits and index bits above the RAM depth are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[OffW-1:0], s_axi_araddr[OffW-1:0], aw_idx_q, ar_idx_q};

endmodule

// File: tb/tb_axil_bram_ctrl.sv
// Directed bench for axil_bram_ctrl: a transaction-level memory/timing model checked every cycle,
// plus literal expectations for the key scenarios. Honours AXIL_BRAM_BOUNDS_CHECK_EN when defined.
module tb_axil_bram_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s_axi_awaddr;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [AW-1:0] s_axi_araddr;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;

  always #5 clk = ~clk;

  axil_bram_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .s_aclk       (clk),
    .s_aresetn    (rst_n),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: word-addressed memory plus per-channel busy/timing state
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [DEPTH];
  int          ncyc = 0;
  bit          wr_busy, aw_held, w_held, rd_busy;
  int          b_due, r_due;
  logic [15:0] m_awaddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  exp_bresp, exp_rresp;
  logic [31:0] exp_rdata;
  int          aw_hs_n, aw_prev_n, w_hs_n, ar_hs_n, ar_prev_n, b_rise_n, r_rise_n;
  int          aw_count = 0, ar_count = 0;
  bit          bv_prev, rv_prev;

  function automatic bit m_oob(input logic [15:0] a);
`ifdef AXIL_BRAM_BOUNDS_CHECK_EN
    return int'(a >> 2) >= int'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_word(input logic [15:0] a);
    return int'(a >> 2) % int'(DEPTH);
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_oob(a)) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) ref_mem[m_word(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
  endfunction

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_busy = 0; aw_held = 0; w_held = 0; rd_busy = 0;
        bv_prev = 0; rv_prev = 0;
      end else begin
        bit e_aw, e_w, e_bv, e_ar, e_rv;
        ncyc++;
        e_aw = !wr_busy && !aw_held;
        e_w  = !wr_busy && !w_held;
        e_bv = wr_busy && (ncyc >= b_due);
        e_ar = !rd_busy;
        e_rv = rd_busy && (ncyc >= r_due);
        chk("awready", 64'(s_axi_awready), 64'(e_aw));
        chk("wready", 64'(s_axi_wready), 64'(e_w));
        chk("bvalid", 64'(s_axi_bvalid), 64'(e_bv));
        chk("arready", 64'(s_axi_arready), 64'(e_ar));
        chk("rvalid", 64'(s_axi_rvalid), 64'(e_rv));
        if (e_bv) chk("bresp", 64'(s_axi_bresp), 64'(exp_bresp));
        if (e_rv) begin
          chk("rdata", 64'(s_axi_rdata), 64'(exp_rdata));
          chk("rresp", 64'(s_axi_rresp), 64'(exp_rresp));
        end
        if (s_axi_bvalid && !bv_prev) b_rise_n = ncyc;
        if (s_axi_rvalid && !rv_prev) r_rise_n = ncyc;
        bv_prev = s_axi_bvalid;
        rv_prev = s_axi_rvalid;
        // Retire responses, then reads sample memory before this cycle's write lands.
        if (e_rv && s_axi_rready) rd_busy = 0;
        if (s_axi_arvalid && s_axi_arready) begin
          exp_rdata = m_oob(s_axi_araddr) ? 32'h0 : ref_mem[m_word(s_axi_araddr)];
          exp_rresp = m_oob(s_axi_araddr) ? 2'b10 : 2'b00;
          rd_busy   = 1;
          r_due     = ncyc + 2;
          ar_prev_n = ar_hs_n;
          ar_hs_n   = ncyc;
          ar_count++;
        end
        if (e_bv && s_axi_bready) begin
          wr_busy = 0; aw_held = 0; w_held = 0;
        end
        if (s_axi_awvalid && s_axi_awready) begin
          aw_held   = 1;
          m_awaddr  = s_axi_awaddr;
          aw_prev_n = aw_hs_n;
          aw_hs_n   = ncyc;
          aw_count++;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_held  = 1;
          m_wdata = s_axi_wdata;
          m_wstrb = s_axi_wstrb;
          w_hs_n  = ncyc;
        end
        if (!wr_busy && aw_held && w_held) begin
          wr_busy   = 1;
          b_due     = ncyc + 2;
          exp_bresp = m_oob(m_awaddr) ? 2'b10 : 2'b00;
          m_write(m_awaddr, m_wdata, m_wstrb);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers: inputs change 1 ns after the rising edge
  // ---------------------------------------------------------------------------
  task automatic do_aw(input logic [15:0] a);
    int n = 0;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 20);
    chk("aw_accept", 64'(s_axi_awready), 64'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_wready && n < 20);
    chk("w_accept", 64'(s_axi_wready), 64'd1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [15:0] a);
    int n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 20);
    chk("ar_accept", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] br);
    int n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 20);
    chk("b_arrive", 64'(s_axi_bvalid), 64'd1);
    br = s_axi_bresp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] br);
    fork
      do_aw(a);
      do_w(d, s);
    join
    wait_b(br);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] rr);
    int n = 0;
    do_ar(a);
    do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 20);
    chk("r_arrive", 64'(s_axi_rvalid), 64'd1);
    d  = s_axi_rdata;
    rr = s_axi_rresp;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0]  br, rr, br2, rr2;
    logic [31:0] d, d2;
    int          c0, n;

    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 1; s_axi_araddr = '0; s_axi_arvalid = 0;
    s_axi_rready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
    chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
    chk("rst_rdata", 64'(s_axi_rdata), 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", 64'(s_axi_awready), 64'd1);
    chk("rel_wready", 64'(s_axi_wready), 64'd1);
    chk("rel_arready", 64'(s_axi_arready), 64'd1);

    // Basic write/read with latencies
    wr(16'h0010, 32'hDEADBEEF, 4'hF, br);
    chk("basic_bresp", 64'(br), 64'd0);
    chk("basic_b_lat", 64'(b_rise_n - imax(aw_hs_n, w_hs_n)), 64'd2);
    rd(16'h0010, d, rr);
    chk("basic_rdata", 64'(d), 64'hDEADBEEF);
    chk("basic_rresp", 64'(rr), 64'd0);
    chk("basic_r_lat", 64'(r_rise_n - ar_hs_n), 64'd2);
    rd(16'h0013, d, rr);
    chk("offset_ignored", 64'(d), 64'hDEADBEEF);

    // Zero strobe leaves RAM untouched but still answers OKAY
    wr(16'h0010, 32'hFFFFFFFF, 4'h0, br);
    chk("zstrb_bresp", 64'(br), 64'd0);
    rd(16'h0010, d, rr);
    chk("zstrb_rdata", 64'(d), 64'hDEADBEEF);

    // W three cycles ahead of AW, single-byte strobe
    wr(16'h0020, 32'h12345678, 4'hF, br);
    fork
      do_w(32'h000000AA, 4'h1);
      begin repeat (3) @(posedge clk); #1; do_aw(16'h0020); end
    join
    wait_b(br);
    chk("wfirst_gap", 64'(aw_hs_n - w_hs_n), 64'd3);
    chk("wfirst_b_lat", 64'(b_rise_n - aw_hs_n), 64'd2);
    rd(16'h0020, d, rr);
    chk("strobe_rdata", 64'(d), 64'h123456AA);

    // Backpressure on both response channels; a second AR must wait
    s_axi_bready = 0;
    s_axi_rready = 0;
    fork
      do_aw(16'h0030);
      do_w(32'hCAFEF00D, 4'hF);
      do_ar(16'h0010);
    join
    repeat (2) @(posedge clk); #1;
    s_axi_araddr  = 16'h0020;
    s_axi_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rdata", 64'(s_axi_rdata), 64'hDEADBEEF);
      chk("stall_bvalid", 64'(s_axi_bvalid), 64'd1);
      chk("stall_rvalid", 64'(s_axi_rvalid), 64'd1);
      chk("stall_arready", 64'(s_axi_arready), 64'd0);
    end
    @(posedge clk); #1;
    s_axi_bready = 1;
    s_axi_rready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 20);
    chk("stall_ar_accept", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 20);
    chk("stall_second_rdata", 64'(s_axi_rdata), 64'h123456AA);
    @(posedge clk); #1;

    // Same-word write and read in one cycle: read-first
    wr(16'h0040, 32'h11112222, 4'hF, br);
    fork
      wr(16'h0040, 32'h00000055, 4'hF, br2);
      rd(16'h0040, d2, rr2);
    join
    chk("collide_old", 64'(d2), 64'h11112222);
    rd(16'h0040, d, rr);
    chk("collide_new", 64'(d), 64'h00000055);

    // Back-to-back writes then reads with ready held high
    c0 = aw_count;
    s_axi_awaddr = 16'h0060; s_axi_wdata = 32'h600D600D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (aw_count < c0 + 2 && n < 30);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("b2b_wr_count", 64'(aw_count - c0), 64'd2);
    chk("b2b_wr_gap", 64'(aw_hs_n - aw_prev_n), 64'd3);
    repeat (3) @(posedge clk); #1;
    c0 = ar_count;
    s_axi_araddr = 16'h0060; s_axi_arvalid = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ar_count < c0 + 2 && n < 30);
    s_axi_arvalid = 0;
    chk("b2b_rd_count", 64'(ar_count - c0), 64'd2);
    chk("b2b_rd_gap", 64'(ar_hs_n - ar_prev_n), 64'd3);
    repeat (3) @(posedge clk); #1;

    // Out-of-range word index (0x1000 -> word 1024)
    wr(16'h0000, 32'h01020304, 4'hF, br);
    wr(16'h1000, 32'hA5A5A5A5, 4'hF, br);
    rd(16'h0000, d, rr);
    rd(16'h1000, d2, rr2);
`ifdef AXIL_BRAM_BOUNDS_CHECK_EN
    chk("oob_bresp", 64'(br), 64'd2);
    chk("oob_word0", 64'(d), 64'h01020304);
    chk("oob_rresp", 64'(rr2), 64'd2);
    chk("oob_rdata", 64'(d2), 64'd0);
`else
    chk("wrap_bresp", 64'(br), 64'd0);
    chk("wrap_word0", 64'(d), 64'hA5A5A5A5);
    chk("wrap_rresp", 64'(rr2), 64'd0);
    chk("wrap_rdata", 64'(d2), 64'hA5A5A5A5);
`endif

    // Reset while a write response is pending
    wr(16'h0050, 32'h77778888, 4'hF, br);
    s_axi_bready = 0;
    fork
      do_aw(16'h0050);
      do_w(32'h00000099, 4'hF);
    join
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 20);
    chk("midrst_bvalid_pre", 64'(s_axi_bvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("midrst_awready", 64'(s_axi_awready), 64'd0);
    chk("midrst_bresp", 64'(s_axi_bresp), 64'd0);
    s_axi_bready = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_awready", 64'(s_axi_awready), 64'd1);
    rd(16'h0050, d, rr);
    chk("midrst_ram_new", 64'(d), 64'h00000099);
    rd(16'h0010, d, rr);
    chk("midrst_ram_kept", 64'(d), 64'hDEADBEEF);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within 200000 ns");
    $fatal(1);
  end

endmodule
